// File: rtl/batcharger_pkg.sv
// Shared types and defaults for the Li-Po charge-sequencing controller.
package batcharger_pkg;

    localparam int unsigned DefDw  = 8;
    localparam int unsigned DefDeb = 4;
    localparam int unsigned DefTw  = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StTc    = 3'd1,
        StCc    = 3'd2,
        StCv    = 3'd3,
        StDone  = 3'd4,
        StFault = 3'd5
    } state_e;

    // Inclusive window compare; callers zero-extend their codes to 32 bits.
    function automatic logic temp_in_window(input logic [31:0] t,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        return (t >= lo) && (t <= hi);
    endfunction

endpackage

// File: rtl/batcharger_if.sv
// Register-bank / ADC side of the charger controller: codes in, mode enables out.
interface batcharger_if
    import batcharger_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned TW = DefTw
);

    logic          en;
    logic [DW-1:0] vbat;
    logic [DW-1:0] ibat;
    logic [DW-1:0] vtemp;
    logic [DW-1:0] vcutoff;
    logic [DW-1:0] vpreset;
    logic [DW-1:0] vtok;
    logic [DW-1:0] iend;
    logic [DW-1:0] tempmin;
    logic [DW-1:0] tempmax;
    logic [TW-1:0] tmax;
    logic          tc;
    logic          cc;
    logic          cv;
    logic          done;
    logic          fault;
    logic [2:0]    state;

    modport master (
        output en, vbat, ibat, vtemp, vcutoff, vpreset, vtok, iend, tempmin, tempmax, tmax,
        input  tc, cc, cv, done, fault, state
    );

    modport slave (
        input  en, vbat, ibat, vtemp, vcutoff, vpreset, vtok, iend, tempmin, tempmax, tmax,
        output tc, cc, cv, done, fault, state
    );

endinterface

// File: rtl/batcharger_deb.sv
// Saturating consecutive-true counter; fire_o marks the Deb-th true cycle in a row.
module batcharger_deb #(
    parameter int unsigned Deb = 4
) (
    input  logic clk,
    input  logic rstz,
    input  logic cond_i,
    input  logic clr_i,
    output logic fire_o
);

    localparam int unsigned CntW = (Deb > 1) ? $clog2(Deb) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Deb - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !cond_i) begin
            cnt_d = '0;
        end else if (cnt_q != Last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign fire_o = cond_i && (cnt_q == Last);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/batcharger_ctrl.sv
// Charge sequencer: IDLE -> TC -> CC -> CV -> DONE with temperature fault and recharge,
// one-hot power-stage enables registered from the state register.
module batcharger_ctrl
    import batcharger_pkg::*;
#(
    parameter int unsigned DW  = DefDw,
    parameter int unsigned DEB = DefDeb,
    parameter int unsigned TW  = DefTw
) (
    input  logic clk,
    input  logic rstz,
    batcharger_if.slave bus
);

    logic [DW-1:0] vbat;
    logic [DW-1:0] ibat;
    logic [DW-1:0] vtemp;
    logic [DW-1:0] vcutoff;
    logic [DW-1:0] vpreset;
    logic [DW-1:0] vtok;
    logic [DW-1:0] iend;
    logic [DW-1:0] tempmin;
    logic [DW-1:0] tempmax;
    logic [TW-1:0] tmax;

    assign vbat    = bus.vbat;
    assign ibat    = bus.ibat;
    assign vtemp   = bus.vtemp;
    assign vcutoff = bus.vcutoff;
    assign vpreset = bus.vpreset;
    assign vtok    = bus.vtok;
    assign iend    = bus.iend;
    assign tempmin = bus.tempmin;
    assign tempmax = bus.tempmax;
    assign tmax    = bus.tmax;

    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          tc_q;
    logic          cc_q;
    logic          cv_q;
    logic          done_q;
    logic          fault_q;

    logic tempok;
    logic active;
    logic fault_cond;
    logic prog_cond;
    logic fault_fire;
    logic prog_fire;
    logic timeout;
    logic state_chg;

    assign tempok = temp_in_window(32'(vtemp), 32'(tempmin), 32'(tempmax));
    assign active = (state_q == StTc) || (state_q == StCc) || (state_q == StCv);
    assign fault_cond = active && !tempok;
    assign timeout = (state_q == StCv) && (timer_q >= tmax);

    // Progression is held off while the fault condition is pending so the fault counter governs.
    always_comb begin
        prog_cond = 1'b0;
        case (state_q)
            StIdle:  prog_cond = bus.en && tempok;
            StTc:    prog_cond = tempok && (vbat >= vtok);
            StCc:    prog_cond = tempok && (vbat >= vcutoff);
            StCv:    prog_cond = tempok && (ibat <= iend);
            StDone:  prog_cond = vbat < vpreset;
            StFault: prog_cond = tempok;
            default: prog_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = StIdle;
        end else if (fault_fire) begin
            state_d = StFault;
        end else if (timeout) begin
            state_d = StDone;
        end else if (prog_fire) begin
            case (state_q)
                StIdle: begin
                    if (vbat < vtok) begin
                        state_d = StTc;
                    end else if (vbat < vcutoff) begin
                        state_d = StCc;
                    end else begin
                        state_d = StCv;
                    end
                end
                StTc:    state_d = StCc;
                StCc:    state_d = StCv;
                StCv:    state_d = StDone;
                StDone:  state_d = (vbat < vtok) ? StTc : StCc;
                StFault: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    assign state_chg = (state_d != state_q);

    // Timer reads 0 on the first CV cycle and saturates at all-ones.
    always_comb begin
        timer_d = '0;
        if (state_q == StCv) begin
            timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
        end
    end

    batcharger_deb #(
        .Deb (DEB)
    ) u_deb_prog (
        .clk    (clk),
        .rstz   (rstz),
        .cond_i (prog_cond),
        .clr_i  (state_chg),
        .fire_o (prog_fire)
    );

    batcharger_deb #(
        .Deb (DEB)
    ) u_deb_fault (
        .clk    (clk),
        .rstz   (rstz),
        .cond_i (fault_cond),
        .clr_i  (state_chg),
        .fire_o (fault_fire)
    );

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= StIdle;
            timer_q <= '0;
            tc_q    <= 1'b0;
            cc_q    <= 1'b0;
            cv_q    <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tc_q    <= (state_q == StTc);
            cc_q    <= (state_q == StCc);
            cv_q    <= (state_q == StCv);
            done_q  <= (state_q == StDone);
            fault_q <= (state_q == StFault);
        end
    end

    assign bus.tc    = tc_q;
    assign bus.cc    = cc_q;
    assign bus.cv    = cv_q;
    assign bus.done  = done_q;
    assign bus.fault = fault_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Directed bench for batcharger_ctrl: charge walk, glitch, fault, timeout, recharge, reset.
module tb_batcharger_ctrl;

    localparam logic [2:0] EIdle  = 3'd0;
    localparam logic [2:0] ETc    = 3'd1;
    localparam logic [2:0] ECc    = 3'd2;
    localparam logic [2:0] ECv    = 3'd3;
    localparam logic [2:0] EDone  = 3'd4;
    localparam logic [2:0] EFault = 3'd5;

    logic clk;
    logic rstz;
    int   checks;
    int   failures;

    batcharger_if #(.DW(8), .TW(16)) bus ();

    batcharger_ctrl #(
        .DW  (8),
        .DEB (4),
        .TW  (16)
    ) dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {bus.tc, bus.cc, bus.cv, bus.done, bus.fault};
    endfunction

    task automatic do_reset();
        rstz        = 1'b0;
        bus.en      = 1'b0;
        bus.vbat    = 8'h40;
        bus.ibat    = 8'h40;
        bus.vtemp   = 8'h50;
        bus.vcutoff = 8'hD0;
        bus.vpreset = 8'hA0;
        bus.vtok    = 8'h60;
        bus.iend    = 8'h10;
        bus.tempmin = 8'h20;
        bus.tempmax = 8'hB0;
        bus.tmax    = 16'hFFFF;
        tick(2);
        rstz = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.state !== EIdle) begin
            failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, EIdle);
        end
        checks++;
        if (outs() !== 5'b00000) begin
            failures++; $display("FAIL reset_outs got=%b exp=00000", outs());
        end
    endtask

    task automatic test_normal_charge();
        do_reset();
        bus.en = 1'b1;
        tick(3);
        checks++;
        if (bus.state !== EIdle) begin
            failures++; $display("FAIL idle_hold got=%0d exp=%0d", bus.state, EIdle);
        end
        tick(1);
        checks++;
        if (bus.state !== ETc) begin
            failures++; $display("FAIL idle_to_tc got=%0d exp=%0d", bus.state, ETc);
        end
        tick(1);
        checks++;
        if (outs() !== 5'b10000) begin
            failures++; $display("FAIL tc_outs got=%b exp=10000", outs());
        end
        bus.vbat = 8'h60;
        tick(3);
        checks++;
        if (bus.state !== ETc) begin
            failures++; $display("FAIL tc_hold got=%0d exp=%0d", bus.state, ETc);
        end
        tick(1);
        checks++;
        if (bus.state !== ECc) begin
            failures++; $display("FAIL tc_to_cc got=%0d exp=%0d", bus.state, ECc);
        end
        tick(1);
        checks++;
        if (outs() !== 5'b01000) begin
            failures++; $display("FAIL cc_outs got=%b exp=01000", outs());
        end
        bus.vbat = 8'hD0;
        tick(4);
        checks++;
        if (bus.state !== ECv) begin
            failures++; $display("FAIL cc_to_cv got=%0d exp=%0d", bus.state, ECv);
        end
        tick(1);
        checks++;
        if (outs() !== 5'b00100) begin
            failures++; $display("FAIL cv_outs got=%b exp=00100", outs());
        end
        bus.ibat = 8'h10;
        tick(3);
        checks++;
        if (bus.state !== ECv) begin
            failures++; $display("FAIL cv_hold got=%0d exp=%0d", bus.state, ECv);
        end
        tick(1);
        checks++;
        if (bus.state !== EDone) begin
            failures++; $display("FAIL cv_to_done got=%0d exp=%0d", bus.state, EDone);
        end
        tick(1);
        checks++;
        if (outs() !== 5'b00010) begin
            failures++; $display("FAIL done_outs got=%b exp=00010", outs());
        end
    endtask

    task automatic test_glitch();
        do_reset();
        bus.en = 1'b1;
        tick(5);
        bus.vbat = 8'h60;
        tick(3);
        bus.vbat = 8'h50;
        tick(6);
        checks++;
        if (bus.state !== ETc || bus.tc !== 1'b1) begin
            failures++;
            $display("FAIL glitch_reject state=%0d tc=%b exp state=%0d tc=1", bus.state, bus.tc, ETc);
        end
    endtask

    task automatic test_temp_fault();
        do_reset();
        bus.vbat = 8'h80;
        bus.en   = 1'b1;
        tick(5);
        checks++;
        if (bus.state !== ECc) begin
            failures++; $display("FAIL idle_to_cc got=%0d exp=%0d", bus.state, ECc);
        end
        bus.vtemp = 8'hB0;
        tick(6);
        checks++;
        if (bus.state !== ECc) begin
            failures++; $display("FAIL temp_at_max got=%0d exp=%0d", bus.state, ECc);
        end
        bus.vtemp = 8'hC0;
        tick(3);
        checks++;
        if (bus.state !== ECc) begin
            failures++; $display("FAIL fault_hold got=%0d exp=%0d", bus.state, ECc);
        end
        tick(1);
        checks++;
        if (bus.state !== EFault) begin
            failures++; $display("FAIL cc_to_fault got=%0d exp=%0d", bus.state, EFault);
        end
        tick(1);
        checks++;
        if (outs() !== 5'b00001) begin
            failures++; $display("FAIL fault_outs got=%b exp=00001", outs());
        end
        bus.vtemp = 8'h50;
        tick(4);
        checks++;
        if (bus.state !== EIdle) begin
            failures++; $display("FAIL fault_to_idle got=%0d exp=%0d", bus.state, EIdle);
        end
        tick(4);
        checks++;
        if (bus.state !== ECc) begin
            failures++; $display("FAIL reenter_cc got=%0d exp=%0d", bus.state, ECc);
        end
    endtask

    task automatic test_cv_timeout();
        do_reset();
        bus.vbat = 8'hD0;
        bus.tmax = 16'd100;
        bus.en   = 1'b1;
        tick(4);
        checks++;
        if (bus.state !== ECv) begin
            failures++; $display("FAIL idle_to_cv got=%0d exp=%0d", bus.state, ECv);
        end
        tick(100);
        checks++;
        if (bus.state !== ECv) begin
            failures++; $display("FAIL cv_100th got=%0d exp=%0d", bus.state, ECv);
        end
        tick(1);
        checks++;
        if (bus.state !== EDone) begin
            failures++; $display("FAIL cv_timeout got=%0d exp=%0d", bus.state, EDone);
        end
    endtask

    task automatic test_recharge_disable();
        do_reset();
        bus.vbat = 8'hD0;
        bus.tmax = 16'd0;
        bus.en   = 1'b1;
        tick(5);
        checks++;
        if (bus.state !== EDone) begin
            failures++; $display("FAIL tmax0_done got=%0d exp=%0d", bus.state, EDone);
        end
        bus.vbat = 8'h90;
        tick(3);
        checks++;
        if (bus.state !== EDone) begin
            failures++; $display("FAIL recharge_hold got=%0d exp=%0d", bus.state, EDone);
        end
        tick(1);
        checks++;
        if (bus.state !== ECc) begin
            failures++; $display("FAIL recharge_cc got=%0d exp=%0d", bus.state, ECc);
        end
        tick(1);
        checks++;
        if (outs() !== 5'b01000) begin
            failures++; $display("FAIL recharge_outs got=%b exp=01000", outs());
        end
        bus.en = 1'b0;
        tick(1);
        checks++;
        if (bus.state !== EIdle) begin
            failures++; $display("FAIL disable_idle got=%0d exp=%0d", bus.state, EIdle);
        end
        tick(1);
        checks++;
        if (outs() !== 5'b00000) begin
            failures++; $display("FAIL disable_outs got=%b exp=00000", outs());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.vbat = 8'hD0;
        bus.en   = 1'b1;
        tick(4);
        tick(10);
        checks++;
        if (dut.timer_q !== 16'd10) begin
            failures++; $display("FAIL cv_timer got=%0d exp=10", dut.timer_q);
        end
        #2;
        rstz = 1'b0;
        #1;
        checks++;
        if (outs() !== 5'b00000 || bus.state !== EIdle) begin
            failures++;
            $display("FAIL async_outs outs=%b state=%0d exp outs=00000 state=0", outs(), bus.state);
        end
        checks++;
        if (dut.timer_q !== 16'd0) begin
            failures++; $display("FAIL async_timer got=%0d exp=0", dut.timer_q);
        end
        tick(1);
        rstz = 1'b1;
        tick(1);
        checks++;
        if (bus.state !== EIdle) begin
            failures++; $display("FAIL post_reset_idle got=%0d exp=%0d", bus.state, EIdle);
        end
        tick(3);
        checks++;
        if (bus.state !== ECv) begin
            failures++; $display("FAIL restart_cv got=%0d exp=%0d", bus.state, ECv);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstz     = 1'b0;
        test_reset();
        test_normal_charge();
        test_glitch();
        test_temp_fault();
        test_cv_timeout();
        test_recharge_disable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
